vdp99_vram_arbiter: RTL and testbench

//  Shares the single-port VRAM of the nouveau-vdp99 between the display fetch engine and the
//  CPU data port, all in the pxclk domain. Display fetches always win their slot. CPU traffic

---
 rtl/vdp99_vram_arbiter.sv | 145 ++++++++++++++
 tb/tb_vdp99_vram_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp99_vram_arbiter.sv
// VRAM slot arbiter for the vdp99: display fetches own any slot they request, the CPU port
// drains a one-entry write buffer and a one-byte read-ahead latch through the leftover slots.
module vdp99_vram_arbiter #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          pxclk,
    input  logic          reset_n,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    input  logic          cpu_addr_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_addr_rd,
    input  logic          cpu_data_wr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_data_rd,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_busy,
    output logic          cpu_ovf,
    output logic [AW-1:0] vram_addr,
    output logic          vram_we,
    output logic [DW-1:0] vram_wdata,
    input  logic [DW-1:0] vram_rdata
);

    localparam logic [1:0] PF_IDLE     = 2'd0;
    localparam logic [1:0] PF_PEND     = 2'd1;
    localparam logic [1:0] PF_INFLIGHT = 2'd2;

    logic [AW-1:0] cpu_ptr;
    logic          wbuf_full;
    logic [AW-1:0] wbuf_addr;
    logic [DW-1:0] wbuf_data;
    logic [1:0]    pf_state;
    logic          pf_stage;
    logic          disp_p1;
    logic          disp_p2;

    logic grant_disp;
    logic grant_wr;
    logic grant_pf;
    logic pf_busy;
    logic pf_done;
    logic any_strobe;

    always_comb begin
        grant_disp = disp_req;
        grant_wr   = !disp_req && wbuf_full;
        grant_pf   = !disp_req && !wbuf_full && (pf_state == PF_PEND);
        pf_busy    = (pf_state != PF_IDLE);
        pf_done    = (pf_state == PF_INFLIGHT) && pf_stage;
        any_strobe = cpu_addr_wr || cpu_data_wr || cpu_data_rd;
    end

    assign cpu_busy = wbuf_full || pf_busy;

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            vram_addr  <= '0;
            vram_we    <= 1'b0;
            vram_wdata <= '0;
        end else begin
            vram_we <= grant_wr;
            if (grant_disp) begin
                vram_addr <= disp_addr;
            end else if (grant_wr) begin
                vram_addr  <= wbuf_addr;
                vram_wdata <= wbuf_data;
            end else if (grant_pf) begin
                vram_addr <= cpu_ptr;
            end
        end
    end

    // Display returns follow their request by exactly two edges, matching the BRAM read latency.
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            disp_p1     <= 1'b0;
            disp_p2     <= 1'b0;
            disp_rvalid <= 1'b0;
            disp_rdata  <= '0;
        end else begin
            disp_p1     <= grant_disp;
            disp_p2     <= disp_p1;
            disp_rvalid <= disp_p2;
            if (disp_p2) begin
                disp_rdata <= vram_rdata;
            end
        end
    end

    // Any CPU strobe supersedes an outstanding prefetch, so a late read result never lands.
    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_ptr   <= '0;
            wbuf_full <= 1'b0;
            wbuf_addr <= '0;
            wbuf_data <= '0;
            pf_state  <= PF_IDLE;
            pf_stage  <= 1'b0;
            cpu_rdata <= '0;
            cpu_ovf   <= 1'b0;
        end else begin
            if (grant_wr) begin
                wbuf_full <= 1'b0;
            end
            if (pf_done) begin
                pf_state <= PF_IDLE;
                if (!any_strobe) begin
                    cpu_rdata <= vram_rdata;
                end
            end
            if (grant_pf) begin
                pf_state <= PF_INFLIGHT;
                pf_stage <= 1'b0;
            end else if (pf_state == PF_INFLIGHT) begin
                pf_stage <= 1'b1;
            end

            if (cpu_addr_wr) begin
                cpu_ptr  <= cpu_addr;
                pf_state <= cpu_addr_rd ? PF_PEND : PF_IDLE;
            end else if (cpu_data_wr) begin
                wbuf_full <= 1'b1;
                wbuf_addr <= cpu_ptr;
                wbuf_data <= cpu_wdata;
                cpu_rdata <= cpu_wdata;
                cpu_ptr   <= cpu_ptr + 1'b1;
                pf_state  <= PF_IDLE;
                if (wbuf_full && !grant_wr) begin
                    cpu_ovf <= 1'b1;
                end
            end else if (cpu_data_rd) begin
                cpu_ptr  <= cpu_ptr + 1'b1;
                pf_state <= PF_PEND;
                if (pf_busy) begin
                    cpu_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vdp99_vram_arbiter.sv
// Bench for vdp99_vram_arbiter: BRAM model, slot-level reference model with cycle-stamped
// returns, per-cycle compare process, and directed scenarios with literal expectations.
module tb_vdp99_vram_arbiter;

    logic        pxclk;
    logic        reset_n;
    logic        disp_req;
    logic [13:0] disp_addr;
    logic        disp_rvalid;
    logic [7:0]  disp_rdata;
    logic        cpu_addr_wr;
    logic [13:0] cpu_addr;
    logic        cpu_addr_rd;
    logic        cpu_data_wr;
    logic [7:0]  cpu_wdata;
    logic        cpu_data_rd;
    logic [7:0]  cpu_rdata;
    logic        cpu_busy;
    logic        cpu_ovf;
    logic [13:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;

    vdp99_vram_arbiter #(.AW(14), .DW(8)) dut (
        .pxclk(pxclk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_addr_wr(cpu_addr_wr), .cpu_addr(cpu_addr), .cpu_addr_rd(cpu_addr_rd),
        .cpu_data_wr(cpu_data_wr), .cpu_wdata(cpu_wdata), .cpu_data_rd(cpu_data_rd),
        .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_ovf(cpu_ovf),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem [0:16383];
    logic [7:0] model_mem [0:16383];

    initial begin
        pxclk = 1'b0;
        forever #5 pxclk = ~pxclk;
    end

    always @(posedge pxclk) begin
        vram_rdata <= mem[vram_addr];
        if (vram_we) mem[vram_addr] <= vram_wdata;
    end

    // Display engine stand-in: streams consecutive fetch addresses while enabled.
    logic        disp_on   = 1'b0;
    logic [13:0] disp_next = '0;
    initial begin
        disp_req  = 1'b0;
        disp_addr = '0;
        forever begin
            @(posedge pxclk);
            #2;
            disp_req  = disp_on;
            disp_addr = disp_next;
            if (disp_on) disp_next = disp_next + 14'd1;
        end
    end

    typedef struct {
        int         due;
        logic [7:0] d;
    } ret_t;

    ret_t        disp_q[$];
    int          cyc        = 0;
    logic [13:0] m_ptr      = '0;
    logic        m_wfull    = 1'b0;
    logic [13:0] m_waddr    = '0;
    logic [7:0]  m_wdata    = '0;
    logic        m_pend     = 1'b0;
    int          m_due      = -1;
    logic [7:0]  m_pfval    = '0;
    logic [7:0]  m_rdata    = '0;
    logic        m_ovf      = 1'b0;
    logic        exp_rvalid = 1'b0;
    logic [7:0]  exp_drdata = '0;
    logic        exp_we     = 1'b0;
    logic [13:0] exp_waddr  = '0;
    logic [7:0]  exp_wdat   = '0;
    logic        exp_busy   = 1'b0;
    logic        pf_busy_pre;
    logic        strobe;

    // Reference model: one VRAM slot per edge, returns scheduled by absolute cycle number.
    always @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            disp_q.delete();
            m_ptr = '0; m_wfull = 1'b0; m_pend = 1'b0; m_due = -1;
            m_rdata = '0; m_ovf = 1'b0;
            exp_rvalid = 1'b0; exp_we = 1'b0; exp_busy = 1'b0;
        end else begin
            cyc = cyc + 1;
            pf_busy_pre = m_pend || (m_due >= cyc);
            strobe = cpu_addr_wr || cpu_data_wr || cpu_data_rd;
            exp_rvalid = 1'b0;
            if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
                exp_rvalid = 1'b1;
                exp_drdata = disp_q[0].d;
                void'(disp_q.pop_front());
            end
            if (m_due == cyc && !strobe) m_rdata = m_pfval;
            if (m_due <= cyc) m_due = -1;
            exp_we = 1'b0;
            if (disp_req) begin
                disp_q.push_back('{due: cyc + 2, d: model_mem[disp_addr]});
            end else if (m_wfull) begin
                model_mem[m_waddr] = m_wdata;
                exp_we = 1'b1; exp_waddr = m_waddr; exp_wdat = m_wdata;
                m_wfull = 1'b0;
            end else if (m_pend) begin
                m_pend = 1'b0;
                m_due = cyc + 2;
                m_pfval = model_mem[m_ptr];
            end
            if (cpu_addr_wr) begin
                m_ptr = cpu_addr; m_pend = cpu_addr_rd; m_due = -1;
            end else if (cpu_data_wr) begin
                if (m_wfull) m_ovf = 1'b1;
                m_wfull = 1'b1; m_waddr = m_ptr; m_wdata = cpu_wdata;
                m_rdata = cpu_wdata; m_ptr = m_ptr + 14'd1;
                m_pend = 1'b0; m_due = -1;
            end else if (cpu_data_rd) begin
                if (pf_busy_pre) m_ovf = 1'b1;
                m_ptr = m_ptr + 14'd1; m_pend = 1'b1; m_due = -1;
            end
            exp_busy = m_wfull || m_pend || (m_due > cyc);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pxclk) begin
        check_output("disp_rvalid", 32'(disp_rvalid), 32'(exp_rvalid));
        if (exp_rvalid) check_output("disp_rdata", 32'(disp_rdata), 32'(exp_drdata));
        check_output("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        check_output("cpu_busy", 32'(cpu_busy), 32'(exp_busy));
        check_output("cpu_ovf", 32'(cpu_ovf), 32'(m_ovf));
        check_output("vram_we", 32'(vram_we), 32'(exp_we));
        if (exp_we) begin
            check_output("vram_addr", 32'(vram_addr), 32'(exp_waddr));
            check_output("vram_wdata", 32'(vram_wdata), 32'(exp_wdat));
        end
    end

    task automatic apply_stimulus(input logic aw, input logic ard, input logic dw, input logic dr,
                                  input logic [13:0] a, input logic [7:0] d);
        cpu_addr_wr = aw; cpu_addr_rd = ard; cpu_data_wr = dw; cpu_data_rd = dr;
        cpu_addr = a; cpu_wdata = d;
        @(posedge pxclk);
        #1;
        cpu_addr_wr = 1'b0; cpu_addr_rd = 1'b0; cpu_data_wr = 1'b0; cpu_data_rd = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge pxclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]       = 8'((i * 7 + 3) & 8'hFF);
            model_mem[i] = 8'((i * 7 + 3) & 8'hFF);
        end
        mem[14'h3FFF]       = 8'hA5;
        model_mem[14'h3FFF] = 8'hA5;
        reset_n = 1'b0;
        cpu_addr_wr = 1'b0; cpu_addr_rd = 1'b0; cpu_data_wr = 1'b0; cpu_data_rd = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        step(3);
        check_output("reset vram_we", 32'(vram_we), 32'h0);
        check_output("reset vram_addr", 32'(vram_addr), 32'h0);
        check_output("reset cpu_rdata", 32'(cpu_rdata), 32'h0);
        check_output("reset cpu_busy", 32'(cpu_busy), 32'h0);
        check_output("reset disp_rvalid", 32'(disp_rvalid), 32'h0);
        reset_n = 1'b1;
        step(1);

        // Reset arriving while a write waits behind display traffic must drop that write.
        disp_on = 1'b1; disp_next = 14'h0600;
        apply_stimulus(1, 0, 0, 0, 14'h0200, 8'h00);
        apply_stimulus(0, 0, 1, 0, 14'h0000, 8'h77);
        step(3);
        check_output("t1 busy before reset", 32'(cpu_busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("t1 async busy", 32'(cpu_busy), 32'h0);
        check_output("t1 async vram_we", 32'(vram_we), 32'h0);
        check_output("t1 async cpu_rdata", 32'(cpu_rdata), 32'h0);
        check_output("t1 async vram_addr", 32'(vram_addr), 32'h0);
        disp_on = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(8);
        check_output("t1 abandoned write", 32'(mem[14'h0200]), 32'h03);

        // Read setup at the top of VRAM, then auto-increment wraps to address 0.
        apply_stimulus(1, 1, 0, 0, 14'h3FFF, 8'h00);
        step(3);
        check_output("t2 rdata 3FFF", 32'(cpu_rdata), 32'hA5);
        check_output("t2 busy idle", 32'(cpu_busy), 32'h0);
        apply_stimulus(0, 0, 0, 1, 14'h0000, 8'h00);
        step(3);
        check_output("t2 rdata wrap 0000", 32'(cpu_rdata), 32'h03);

        apply_stimulus(1, 0, 0, 0, 14'h0100, 8'h00);
        apply_stimulus(0, 0, 1, 0, 14'h0000, 8'h11);
        step(4);
        apply_stimulus(0, 0, 1, 0, 14'h0000, 8'h22);
        step(4);
        check_output("t3 mem 0100", 32'(mem[14'h0100]), 32'h11);
        check_output("t3 mem 0101", 32'(mem[14'h0101]), 32'h22);
        check_output("t3 ovf", 32'(cpu_ovf), 32'h0);
        check_output("t3 rdata echo", 32'(cpu_rdata), 32'h22);

        apply_stimulus(1, 0, 0, 0, 14'h0300, 8'h00);
        disp_on = 1'b1; disp_next = 14'h0400;
        apply_stimulus(0, 0, 1, 0, 14'h0000, 8'h5A);
        step(20);
        check_output("t4 busy held", 32'(cpu_busy), 32'h1);
        check_output("t4 write held", 32'(mem[14'h0300]), 32'h03);
        disp_on = 1'b0;
        step(4);
        check_output("t4 write landed", 32'(mem[14'h0300]), 32'h5A);
        check_output("t4 busy clear", 32'(cpu_busy), 32'h0);

        disp_on = 1'b1; disp_next = 14'h0800;
        step(3);
        check_output("t5 first rvalid", 32'(disp_rvalid), 32'h1);
        check_output("t5 rdata 0800", 32'(disp_rdata), 32'h03);
        step(1);
        check_output("t5 rdata 0801", 32'(disp_rdata), 32'h0A);
        step(10);

        // Back-to-back writes under saturation: only the second, at the incremented address, lands.
        apply_stimulus(1, 0, 0, 0, 14'h0500, 8'h00);
        apply_stimulus(0, 0, 1, 0, 14'h0000, 8'h66);
        apply_stimulus(0, 0, 1, 0, 14'h0000, 8'h77);
        step(5);
        check_output("t6 ovf set", 32'(cpu_ovf), 32'h1);
        check_output("t6 busy", 32'(cpu_busy), 32'h1);
        disp_on = 1'b0;
        step(5);
        check_output("t6 mem 0501", 32'(mem[14'h0501]), 32'h77);
        check_output("t6 mem 0500", 32'(mem[14'h0500]), 32'h03);
        check_output("t6 ovf sticky", 32'(cpu_ovf), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
